// File: rtl/mem_pkg.sv
// Shared types and widths for the memory responder slice.
package mem_pkg;
   localparam int XLEN   = 32;
   localparam int BE_W   = 4;
   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
interface mem_responder_if;
   import mem_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [BE_W-1:0] req_be;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_responder_word_ram.sv
// Word array with per-byte write enables and a registered read port; storage is not reset.
module word_ram
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            we_i,
   input  logic            re_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [BE_W-1:0] be_i,
   output logic [XLEN-1:0] rdata_o
);
   logic [XLEN-1:0] mem [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;

   for (genvar b = 0; b < BE_W; b++) begin : g_byte
      always_ff @(posedge clk) begin
         if (we_i && be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait WAIT_CYCLES, commit, hold response until consumed.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_W-1:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

   mem_state_t      state_q;
   logic [WAIT_W-1:0] cnt_q;
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [BE_W-1:0] be_q;
   logic            rdy_q;
   logic            rsp_valid_q;
   logic            rsp_err_q;
   logic            rd_sel_q;

   logic            accept;
   logic            commit;
   logic            acc_we;
   logic [XLEN-1:0] acc_addr;
   logic [XLEN-1:0] acc_wdata;
   logic [BE_W-1:0] acc_be;
   logic            acc_err;
   logic [XLEN-1:0] ram_rdata;

   assign accept = (state_q == IDLE) && bus.req_valid;

   // With zero wait states the commit happens on the accept edge, so use the live request.
   assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
   assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
   assign acc_be    = (state_q == IDLE) ? bus.req_be    : be_q;

   assign acc_err = (acc_addr[1:0] != 2'b00) ||
                    (acc_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS));

   assign commit = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == '0));

   word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk     (clk),
      .we_i    (commit && acc_we && !acc_err),
      .re_i    (commit && !acc_we && !acc_err),
      .addr_i  (acc_addr[AW+1:2]),
      .wdata_i (acc_wdata),
      .be_i    (acc_be),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rdy_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_sel_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               we_q    <= bus.req_we;
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               be_q    <= bus.req_be;
               rdy_q   <= 1'b0;
               cnt_q   <= CNT_INIT;
               state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
               if (cnt_q == '0) state_q <= RESP;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
               state_q     <= IDLE;
               rdy_q       <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rd_sel_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
         if (commit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rd_sel_q    <= !acc_we && !acc_err;
         end
      end
   end

   assign bus.req_ready = rdy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   // The RAM read register has no reset; gating keeps writes, errors and reset at zero.
   assign bus.rsp_rdata = rd_sel_q ? ram_rdata : '0;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle core's memory port. The core's FETCH and MEMORY states issue instruction and data requests; this block answers them. It accepts one request at a time over a valid/ready handshake, waits a configurable number of wait states, and commits writes or returns read data. It then presents a response that is held until the core consumes it.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two.
- WAIT_CYCLES, 1: wait states between request acceptance and response; range 0..15.

Ports:
- clk, input, 1: single clock; all state changes on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: core presents a request.
- req_ready, output, 1: responder can accept a request.
- req_we, input, 1: 1 = write, 0 = read.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: write data.
- req_be, input, 4: byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: core consumes response.
- rsp_rdata, output, 32: read data; 0 for writes and errors.
- rsp_err, output, 1: access error.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we/addr/wdata/be.
  - Go to WAIT, load the wait counter with WAIT_CYCLES-1; go directly to RESP if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At counter==0, go to RESP and commit the access on that same edge.
- Commit:
  - Error if req_addr[1:0]!=0 or req_addr[31:2] >= DEPTH_WORDS. On error: rsp_err=1, rsp_rdata=0, no write.
  - Write: update only the bytes with req_be set. be=4'b0000 is a legal no-op write with rsp_err=0, rsp_rdata=0.
  - Read: rsp_rdata is the stored word, registered at the commit edge.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - Then go to IDLE.
  - req_ready stays 0 in RESP, so there is no same-cycle back-to-back acceptance.
- Requests arriving outside IDLE are not accepted. The core must hold req_* stable until req_ready.
- Storage contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: handshake in cycle t gives rsp_valid=1 in cycle t+WAIT_CYCLES+1.
- Minimum request-to-request spacing: WAIT_CYCLES+2 cycles, with rsp_ready tied high.
- A write is visible to any request accepted after its response handshake.
- Reset asserted mid-operation:
  - In WAIT, the pending access is discarded and no write occurs.
  - In RESP, the write has already been committed and the response is dropped.
  - Outputs return to reset values immediately, without waiting for a clock edge.
- rsp_ready held 0 for any number of cycles: response stays held and no new request is accepted.

## Structure
- Shared package mem_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t.
  - Widths: XLEN=32, BE_W=4.
  - Constant WAIT_W=4.
- Sub-module word_ram: synchronous-write, registered-read word array with per-byte write enable, parameterized by DEPTH_WORDS. No reset on storage.
- Top level holds the FSM, wait counter, request latch, error decode and output registers.

## Test plan
- Reset then idle, reset_n low: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Write then read, WAIT_CYCLES=1:
  - Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10.
  - rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each handshake.
- Partial write:
  - Write 0x000000AA with be=4'b0001, then 0x00CC0000 with be=4'b0100, to 0x10.
  - Reading 0x10 returns 0xDECCBEAA.
- Errors:
  - Read 0x13 gives rsp_err=1, rsp_rdata=0.
  - Write to byte address 4*DEPTH_WORDS gives rsp_err=1, and a later read of word 0 is unchanged.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid rises: rsp_valid and rsp_rdata stay stable and req_ready=0 throughout.
  - After consumption, req_ready=1 the next cycle.
- WAIT_CYCLES=0 and reset mid-WAIT:
  - With WAIT_CYCLES=0, rsp_valid appears 1 cycle after the handshake.
  - With WAIT_CYCLES=3, pulse reset_n low in WAIT during a write of 0x12345678 to 0x20. A later read of 0x20 returns the pre-write value.
